// File: rtl/alt_dprio_responder.sv
// alt_dprio_responder: DPRIO slave model with per-quad register file and programmable busy handshake
module alt_dprio_responder #(
  parameter logic [8:0]  QUAD_ID    = 9'd0,
  parameter int          ADDR_BITS  = 4,
  parameter int          RD_LATENCY = 3,
  parameter int          WR_LATENCY = 2,
  parameter logic [15:0] INIT_VALUE = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [8:0]  quad_addr,
  input  logic [15:0] dprio_addr,
  input  logic [15:0] dprio_dataout,
  input  logic        dprio_rden,
  input  logic        dprio_wren,
  output logic        dprio_busy,
  output logic [15:0] dprio_datain,
  output logic        access_error,
  output logic [15:0] txn_count
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  if (RD_LATENCY < 1 || RD_LATENCY > 15 || WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_bad_latency
    $fatal(1, "alt_dprio_responder: latency parameters must be 1..15");
  end

  logic [1:0]           state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [15:0]          data_q;
  logic                 wr_q;
  logic                 ok_q;
  logic                 req_q;
  logic [15:0]          regs [DEPTH];
  logic                 req;
  logic                 accept;
  logic                 in_range;
  logic                 done;

  assign req        = (quad_addr == QUAD_ID) && (dprio_rden || dprio_wren);
  assign accept     = req && (state != BUSY);
  assign in_range   = dprio_addr[15:ADDR_BITS] == '0;
  assign done       = (state == BUSY) && (cnt == 4'd1);
  assign dprio_busy = state == BUSY;

  // Request capture, latency countdown, commit on entry to COMPLETE, sticky error tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      ok_q         <= 1'b0;
      req_q        <= 1'b0;
      dprio_datain <= '0;
      access_error <= 1'b0;
      txn_count    <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= INIT_VALUE;
    end else begin
      req_q <= req;
      // A strobe held over from the accepted request is not a new request; only a fresh rise while busy is
      access_error <= access_error
                    || (accept && ((dprio_rden && dprio_wren) || !in_range))
                    || (dprio_busy && req && !req_q);
      if (accept) begin
        state  <= BUSY;
        cnt    <= dprio_wren ? 4'(WR_LATENCY) : 4'(RD_LATENCY);
        addr_q <= dprio_addr[ADDR_BITS-1:0];
        data_q <= dprio_dataout;
        wr_q   <= dprio_wren;
        ok_q   <= in_range;
      end else if (done) begin
        state     <= COMPLETE;
        txn_count <= txn_count + 16'd1;
        if (wr_q && ok_q) regs[addr_q] <= data_q;
        if (!wr_q) dprio_datain <= ok_q ? regs[addr_q] : 16'h0000;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alt_dprio_responder.sv
// tb_alt_dprio_responder: directed scoreboard bench for the DPRIO responder
module tb_alt_dprio_responder;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  quad_addr = '0;
  logic [15:0] dprio_addr = '0;
  logic [15:0] dprio_dataout = '0;
  logic        dprio_rden = 1'b0;
  logic        dprio_wren = 1'b0;
  logic        dprio_busy;
  logic [15:0] dprio_datain;
  logic        access_error;
  logic [15:0] txn_count;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] mem [16];
  logic [15:0] sb [$];
  logic [15:0] txn_m = '0;
  logic        err_m = 1'b0;
  logic [15:0] last_rd = '0;

  alt_dprio_responder dut (
    .clock(clock), .reset_n(reset_n), .quad_addr(quad_addr), .dprio_addr(dprio_addr),
    .dprio_dataout(dprio_dataout), .dprio_rden(dprio_rden), .dprio_wren(dprio_wren),
    .dprio_busy(dprio_busy), .dprio_datain(dprio_datain), .access_error(access_error),
    .txn_count(txn_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge, optionally pulse wren mid-busy, then check the handshake
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input bit pulse);
    int n;
    bit ok;
    ok = a[15:4] == 12'h000;
    if (wr) begin
      if (ok) mem[a[3:0]] = d;
    end else sb.push_back(ok ? mem[a[3:0]] : 16'h0000);
    if ((rd && wr) || !ok || pulse) err_m = 1'b1;
    txn_m++;
    quad_addr = 9'd0; dprio_addr = a; dprio_dataout = d; dprio_rden = rd; dprio_wren = wr;
    @(posedge clock);
    @(negedge clock);
    dprio_rden = 1'b0; dprio_wren = 1'b0;
    n = 0;
    while (dprio_busy && n < 40) begin
      n++;
      if (pulse) begin
        dprio_addr = 16'h0002; dprio_dataout = 16'hDEAD; dprio_wren = (n == 2);
      end
      @(negedge clock);
    end
    check({tag, "_busy_cycles"}, n, wr ? 2 : 3);
    if (!wr) begin
      last_rd = sb.pop_front();
      check({tag, "_datain"}, dprio_datain, last_rd);
    end
    check({tag, "_txn_count"}, txn_count, txn_m);
    check({tag, "_access_error"}, access_error, err_m);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clock);
    check("rst_busy", dprio_busy, 0);
    check("rst_datain", dprio_datain, 0);
    check("rst_err", access_error, 0);
    check("rst_txn", txn_count, 0);
    reset_n = 1'b1;
    @(negedge clock);
    txn("rd5", 1, 0, 16'h0005, 16'h0000, 0);
    @(negedge clock);
    txn("wr2", 0, 1, 16'h0002, 16'hA5C3, 0);
    txn("rd2_b2b", 1, 0, 16'h0002, 16'h0000, 0);
    quad_addr = 9'd1; dprio_addr = 16'h0002; dprio_rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("quad_miss_busy", dprio_busy, 0);
    end
    dprio_rden = 1'b0; quad_addr = 9'd0;
    check("quad_miss_datain", dprio_datain, last_rd);
    check("quad_miss_txn", txn_count, txn_m);
    check("quad_miss_err", access_error, 0);
    txn("rd4_pulse", 1, 0, 16'h0004, 16'h0000, 1);
    @(negedge clock);
    txn("rdwr7", 1, 1, 16'h0007, 16'h1234, 0);
    txn("rd7", 1, 0, 16'h0007, 16'h0000, 0);
    txn("rd2_after_pulse", 1, 0, 16'h0002, 16'h0000, 0);
    txn("wr_oor", 0, 1, 16'h0010, 16'hBEEF, 0);
    txn("rd0_after_oor", 1, 0, 16'h0000, 16'h0000, 0);
    txn("rd_oor", 1, 0, 16'h0010, 16'h0000, 0);
    @(negedge clock);
    dprio_addr = 16'h0003; dprio_dataout = 16'h5555; dprio_wren = 1'b1;
    @(posedge clock);
    @(negedge clock);
    dprio_wren = 1'b0;
    check("midwr_busy_before", dprio_busy, 1);
    reset_n = 1'b0;
    #1;
    check("midwr_busy_reset", dprio_busy, 0);
    check("midwr_txn_reset", txn_count, 0);
    check("midwr_err_reset", access_error, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    sb.delete();
    txn_m = '0; err_m = 1'b0;
    @(negedge clock);
    txn("rd3_after_reset", 1, 0, 16'h0003, 16'h0000, 0);
    txn("rd2_after_reset", 1, 0, 16'h0002, 16'h0000, 0);
    txn("rdwr9", 1, 1, 16'h0009, 16'h7777, 0);
    txn("rd9", 1, 0, 16'h0009, 16'h0000, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
